// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   Byte-wide transmit FIFO feeding an 8N1 UART serialiser (LSB first, idle
//   high). Each serial bit lasts baud_div clocks; baud_div is captured when a
//   byte is popped, so a frame always runs at one rate. A pop at the end of a
//   STOP bit starts the next START bit on the same edge.
//
// Ports
//   wb_clk_i    in   clock, rising edge
//   wb_rst_i    in   asynchronous active-high reset
//   baud_div    in   clocks per serial bit (0 behaves as 1)
//   tx_data     in   byte to enqueue
//   tx_valid    in   tx_data valid; accepted when tx_ready is high
//   tx_ready    out  FIFO has a free slot
//   tx          out  serial line
//   busy        out  frame in progress or FIFO non-empty
//   fifo_level  out  FIFO occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
   parameter int DIV_W = 16,
   parameter int DEPTH = 4
) (
   input  logic                     wb_clk_i,
   input  logic                     wb_rst_i,
   input  logic [DIV_W-1:0]         baud_div,
   input  logic [7:0]               tx_data,
   input  logic                     tx_valid,
   output logic                     tx_ready,
   output logic                     tx,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

   logic [7:0]       mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   state_e           state_q, state_d;
   logic [7:0]       shift_q, shift_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] baud_cnt_q, baud_cnt_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic             tx_q, tx_d;
   logic             push, pop, bit_end;
   logic [DIV_W-1:0] eff_div;

   // Ready is derived from the registered level only, so a pop on the same
   // edge never lets a push into a full FIFO.
   assign tx_ready   = (level_q < FULL_LVL);
   assign push       = tx_valid && tx_ready;
   assign eff_div    = (baud_div == '0) ? DIV_W'(1) : baud_div;
   // div_q is at least 1 whenever the FSM is outside IDLE.
   assign bit_end    = (baud_cnt_q == (div_q - DIV_W'(1)));

   assign tx         = tx_q;
   assign busy       = (state_q != IDLE) || (level_q != '0);
   assign fifo_level = level_q;

   // -------------------------------------------------------------------------
   // Serialiser next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves
      // it unassigned; otherwise synthesis infers a latch.
      state_d    = state_q;
      shift_d    = shift_q;
      div_d      = div_q;
      baud_cnt_d = baud_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      tx_d       = tx_q;
      pop        = 1'b0;

      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            pop  = (level_q != '0);
         end
         START: begin
            if (bit_end) begin
               baud_cnt_d = '0;
               bit_cnt_d  = '0;
               state_d    = DATA;
               tx_d       = shift_q[0];
            end else begin
               baud_cnt_d = baud_cnt_q + DIV_W'(1);
            end
         end
         DATA: begin
            if (bit_end) begin
               baud_cnt_d = '0;
               if (bit_cnt_q == 3'd7) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  shift_d   = {1'b0, shift_q[7:1]};
                  tx_d      = shift_q[1];
               end
            end else begin
               baud_cnt_d = baud_cnt_q + DIV_W'(1);
            end
         end
         STOP: begin
            if (bit_end) begin
               baud_cnt_d = '0;
               if (level_q != '0) begin
                  pop = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               baud_cnt_d = baud_cnt_q + DIV_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // A pop always starts a fresh frame: load the head byte, capture the
      // divisor and drive the START bit from the next edge.
      if (pop) begin
         shift_d    = mem_q[rd_ptr_q];
         div_d      = eff_div;
         baud_cnt_d = '0;
         bit_cnt_d  = '0;
         state_d    = START;
         tx_d       = 1'b0;
      end
   end

   // -------------------------------------------------------------------------
   // FIFO pointer / level next-state
   // -------------------------------------------------------------------------
   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its pre-edge value, independent of statement order.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         shift_q    <= '0;
         div_q      <= '0;
         baud_cnt_q <= '0;
         bit_cnt_q  <= '0;
         tx_q       <= 1'b1;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         shift_q    <= shift_d;
         div_q      <= div_d;
         baud_cnt_q <= baud_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         tx_q       <= tx_d;
      end
   end

   // NOTE: the storage array has no reset; entries are only read after being
   // written, and leaving it out lets it map onto plain RAM/flops without a
   // reset tree.
   always_ff @(posedge wb_clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= tx_data;
      end
   end

endmodule
